// File: rtl/ama_riscv_hazard_pkg.sv
// Shared types and width helpers for the ID-stage hazard/forwarding control.
// Optional perf counters in the top are enabled by AMA_RISCV_HAZARD_PERF_CNT_EN.
package ama_riscv_hazard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int FWD_RF    = 0;

    typedef enum logic [1:0] {
        OP_ALU  = 2'd0,
        OP_LOAD = 2'd1,
        OP_LONG = 2'd2,
        OP_RSVD = 2'd3
    } op_class_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 we;
        logic                 is_load;
    } shadow_entry_t;

    function automatic int fwd_sel_w(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Reserved encoding behaves exactly like an ALU op.
    function automatic op_class_t decode_op(input logic [1:0] raw);
        case (raw)
            2'd1:    return OP_LOAD;
            2'd2:    return OP_LONG;
            default: return OP_ALU;
        endcase
    endfunction

endpackage

// File: rtl/ama_riscv_scoreboard.sv
// Long-latency (mul/div) scoreboard: per-register pending bits, in-flight
// counter and a sticky underflow flag for a retire with nothing outstanding.
module ama_riscv_scoreboard
    import ama_riscv_hazard_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int NREG            = 32,
    localparam int CW              = cnt_w(MAX_OUTSTANDING)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set,
    input  logic [REG_IDX_W-1:0] i_set_rd,
    input  logic                 i_clr,
    input  logic [REG_IDX_W-1:0] i_clr_rd,
    output logic [NREG-1:0]      o_pending,
    output logic [CW-1:0]        o_outstanding,
    output logic                 o_full,
    output logic                 o_err_underflow
);

    logic [NREG-1:0] r_pending;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_underflow;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set && (i_set_rd != '0)) w_set_mask[i_set_rd] = 1'b1;
        if (i_clr)                     w_clr_mask[i_clr_rd] = 1'b1;
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_underflow = 1'b0;
        case ({i_set, i_clr})
            2'b10: w_cnt_nxt = r_cnt + CW'(1);
            2'b01: begin
                if (r_cnt == '0) w_underflow = 1'b1;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            2'b11: if (r_cnt == '0) w_underflow = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the pending vector is reset along with the counter: it is control
    // state, and a stale bit would stall a freshly reset core forever.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            // Clear first, then set: an issue to the same rd wins.
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_cnt     <= w_cnt_nxt;
            if (w_underflow) r_err <= 1'b1;
        end
    end

    assign o_pending       = r_pending;
    assign o_outstanding   = r_cnt;
    assign o_full          = (r_cnt == CW'(MAX_OUTSTANDING));
    assign o_err_underflow = r_err;

endmodule

// File: rtl/ama_riscv_hazard_ctrl.sv
// ID-stage hazard control: shadow pipeline forwarding, load-use and long-op
// stalls, bubble injection. AMA_RISCV_HAZARD_PERF_CNT_EN adds stall counters.
module ama_riscv_hazard_ctrl
    import ama_riscv_hazard_pkg::*;
#(
    parameter  int NUM_FWD_STAGES  = 2,
    parameter  int LOAD_STAGE      = 1,
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int NREG            = 32,
    localparam int FSW             = fwd_sel_w(NUM_FWD_STAGES),
    localparam int OCW             = cnt_w(MAX_OUTSTANDING)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_valid_id,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [REG_IDX_W-1:0] rd_id,
    input  logic                 reg_we_id,
    input  logic [1:0]           op_class_id,
    input  logic                 long_done,
    input  logic [REG_IDX_W-1:0] long_done_rd,
    input  logic                 flush,
    input  logic                 stall_ext,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic [FSW-1:0]       fwd_a_sel,
    output logic [FSW-1:0]       fwd_b_sel,
    output logic [OCW-1:0]       outstanding,
    output logic                 err_underflow,
    output logic [31:0]          perf_lu_stalls,
    output logic [31:0]          perf_long_stalls
);

    shadow_entry_t        r_shadow [NUM_FWD_STAGES];
    shadow_entry_t        w_new_entry;
    op_class_t            w_op;
    logic [REG_IDX_W-1:0] w_rs   [2];
    logic                 w_used [2];
    logic [FSW-1:0]       w_sel  [2];
    logic                 w_lu   [2];
    logic [NREG-1:0]      w_pending;
    logic                 w_full;
    logic                 w_lu_hz;
    logic                 w_sb_hz;
    logic                 w_hz;
    logic                 w_issue;
    logic                 w_long_issue;
    logic                 w_stall;
    logic                 w_bubble;

    assign w_op      = decode_op(op_class_id);
    assign w_rs[0]   = rs1_id;
    assign w_rs[1]   = rs2_id;
    assign w_used[0] = rs1_used;
    assign w_used[1] = rs2_used;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_sel[s] = FSW'(FWD_RF);
            w_lu[s]  = 1'b0;
            if (w_used[s] && (w_rs[s] != '0)) begin
                // Walk oldest to youngest so the youngest match overrides.
                for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                    if (r_shadow[k].valid && r_shadow[k].we && (r_shadow[k].rd == w_rs[s])) begin
                        if (r_shadow[k].is_load && (k < LOAD_STAGE)) begin
                            w_sel[s] = FSW'(FWD_RF);
                            w_lu[s]  = 1'b1;
                        end else begin
                            w_sel[s] = FSW'(k + 1);
                            w_lu[s]  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // A retire this cycle frees a slot, so a LONG op at the limit may issue.
    assign w_lu_hz = w_lu[0] | w_lu[1];
    assign w_sb_hz = (rs1_used  && w_pending[rs1_id])
                   | (rs2_used  && w_pending[rs2_id])
                   | (reg_we_id && w_pending[rd_id])
                   | ((w_op == OP_LONG) && w_full && !long_done);

    assign w_hz         = inst_valid_id & (w_lu_hz | w_sb_hz);
    assign w_issue      = inst_valid_id & ~w_hz & ~flush & ~stall_ext;
    assign w_long_issue = w_issue & (w_op == OP_LONG);

    always_comb begin
        w_new_entry = '0;
        if (w_issue) begin
            w_new_entry.valid   = 1'b1;
            w_new_entry.rd      = rd_id;
            w_new_entry.we      = reg_we_id && (w_op != OP_LONG);
            w_new_entry.is_load = (w_op == OP_LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_FWD_STAGES; k++) r_shadow[k] <= '0;
        end else if (!stall_ext) begin
            r_shadow[0] <= w_new_entry;
            for (int k = 1; k < NUM_FWD_STAGES; k++) r_shadow[k] <= r_shadow[k-1];
        end
    end

    ama_riscv_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .NREG            (NREG)
    ) u_scoreboard (
        .clk             (clk),
        .rst             (rst),
        .i_set           (w_long_issue),
        .i_set_rd        (rd_id),
        .i_clr           (long_done),
        .i_clr_rd        (long_done_rd),
        .o_pending       (w_pending),
        .o_outstanding   (outstanding),
        .o_full          (w_full),
        .o_err_underflow (err_underflow)
    );

    // Freeze beats flush beats hazard; everything is forced low while in reset.
    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        if (!rst) begin
            w_stall  = 1'b0;
        end else if (stall_ext) begin
            w_stall  = 1'b1;
        end else if (flush) begin
            w_bubble = 1'b1;
        end else if (w_hz) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end
    end

    assign stall_if  = w_stall;
    assign stall_id  = w_stall;
    assign bubble_ex = w_bubble;
    assign fwd_a_sel = rst ? w_sel[0] : FSW'(FWD_RF);
    assign fwd_b_sel = rst ? w_sel[1] : FSW'(FWD_RF);

`ifdef AMA_RISCV_HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_long;
    logic        w_counted;

    assign w_counted = w_hz & ~stall_ext & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_lu   <= '0;
            r_perf_long <= '0;
        end else begin
            if (w_counted && w_lu_hz && (r_perf_lu != '1))   r_perf_lu   <= r_perf_lu + 32'd1;
            if (w_counted && w_sb_hz && (r_perf_long != '1)) r_perf_long <= r_perf_long + 32'd1;
        end
    end

    assign perf_lu_stalls   = r_perf_lu;
    assign perf_long_stalls = r_perf_long;
`else
    assign perf_lu_stalls   = '0;
    assign perf_long_stalls = '0;
`endif

endmodule
